// File: rtl/uc_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes
// and the datapath select/operation codes driven by uc_multiciclo.
package uc_pkg;

   typedef enum logic [3:0] {
      S_RESET  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC_R = 4'd3,
      S_EXEC_I = 4'd4,
      S_ADDR   = 4'd5,
      S_MEM_RD = 4'd6,
      S_MEM_WR = 4'd7,
      S_WB_ALU = 4'd8,
      S_WB_MEM = 4'd9,
      S_BRANCH = 4'd10,
      S_JAL    = 4'd11,
      S_JALR   = 4'd12,
      S_LUI    = 4'd13,
      S_TRAP   = 4'd14
   } state_t;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LUI    = 7'h37;

   localparam logic [1:0] ASRC_PC    = 2'b00;
   localparam logic [1:0] ASRC_RS1   = 2'b01;
   localparam logic [1:0] ASRC_OLDPC = 2'b10;

   localparam logic [1:0] BSRC_RS2  = 2'b00;
   localparam logic [1:0] BSRC_FOUR = 2'b01;
   localparam logic [1:0] BSRC_IMM  = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_RTYPE = 2'b10;
   localparam logic [1:0] ALU_ITYPE = 2'b11;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MDR    = 2'b01;
   localparam logic [1:0] WB_PC4    = 2'b10;
   localparam logic [1:0] WB_IMM    = 2'b11;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/uc_mem_timer.sv
// Memory wait-state counter: counts stalled request cycles and flags a timeout
// when the limit is reached with the access still not ready.
module uc_mem_timer #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic ready,
   output logic timeout
);

   localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

   logic [CW-1:0] count;

   // Saturates at LIMIT so a disabled timeout (limit 0) never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (!active || ready)
         count <= '0;
      else if (count != LIMIT)
         count <= count + 1'b1;
   end

   assign timeout = (MEM_TIMEOUT != 0) && active && !ready && (count == LIMIT);

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle RV32I control unit: Moore FSM over FETCH/DECODE/EXECUTE/MEM/WB
// with memory timeout and sticky trap for illegal opcodes and bus errors.
module uc_multiciclo
   import uc_pkg::*;
#(
   parameter int unsigned OPCODE_W        = 7,
   parameter int unsigned MEM_TIMEOUT     = 16,
   parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [2:0]          funct3,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                ir_write,
   output logic                mem_req,
   output logic                mem_we,
   output logic                mem_addr_sel,
   output logic                reg_write,
   output logic [1:0]          alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          alu_op,
   output logic [2:0]          imm_sel,
   output logic [1:0]          wb_sel,
   output logic                pc_src,
   output logic                trap,
   output logic                bus_err,
   output logic [3:0]          state_dbg
);

   state_t     state, state_next;
   logic       timeout;
   logic [6:0] op7;

   assign op7       = 7'(opcode);
   assign state_dbg = state;

   uc_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .active  (mem_req),
      .ready   (mem_ready),
      .timeout (timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_RESET;
         trap    <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next == S_TRAP && state != S_TRAP)
            trap <= 1'b1;
         if (timeout)
            bus_err <= 1'b1;
      end
   end

   always_comb begin
      state_next   = state;
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      reg_write    = 1'b0;
      alu_src_a    = ASRC_PC;
      alu_src_b    = BSRC_RS2;
      alu_op       = ALU_ADD;
      imm_sel      = IMM_I;
      wb_sel       = WB_ALUOUT;
      pc_src       = 1'b0;

      case (state)
         S_RESET: state_next = S_FETCH;

         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               alu_src_a  = ASRC_PC;
               alu_src_b  = BSRC_FOUR;
               state_next = S_DECODE;
            end else if (timeout) begin
               state_next = S_TRAP;
            end
         end

         S_DECODE: begin
            alu_src_a = ASRC_OLDPC;
            alu_src_b = BSRC_IMM;
            imm_sel   = IMM_B;
            case (op7)
               OP_R:               state_next = S_EXEC_R;
               OP_I:               state_next = S_EXEC_I;
               OP_LOAD, OP_STORE:  state_next = S_ADDR;
               OP_BRANCH:          state_next = S_BRANCH;
               OP_JAL:             state_next = S_JAL;
               OP_JALR:            state_next = S_JALR;
               OP_LUI:             state_next = S_LUI;
               default:            state_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
            endcase
         end

         S_EXEC_R: begin
            alu_src_a  = ASRC_RS1;
            alu_src_b  = BSRC_RS2;
            alu_op     = ALU_RTYPE;
            state_next = S_WB_ALU;
         end

         S_EXEC_I: begin
            alu_src_a  = ASRC_RS1;
            alu_src_b  = BSRC_IMM;
            imm_sel    = IMM_I;
            alu_op     = ALU_ITYPE;
            state_next = S_WB_ALU;
         end

         S_ADDR: begin
            alu_src_a = ASRC_RS1;
            alu_src_b = BSRC_IMM;
            if (op7 == OP_STORE) begin
               imm_sel    = IMM_S;
               state_next = S_MEM_WR;
            end else begin
               imm_sel    = IMM_I;
               state_next = S_MEM_RD;
            end
         end

         S_MEM_RD: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            if (mem_ready)    state_next = S_WB_MEM;
            else if (timeout) state_next = S_TRAP;
         end

         S_MEM_WR: begin
            mem_req      = 1'b1;
            mem_we       = 1'b1;
            mem_addr_sel = 1'b1;
            if (mem_ready)    state_next = S_FETCH;
            else if (timeout) state_next = S_TRAP;
         end

         S_WB_ALU: begin
            reg_write  = 1'b1;
            wb_sel     = WB_ALUOUT;
            state_next = S_FETCH;
         end

         S_WB_MEM: begin
            reg_write  = 1'b1;
            wb_sel     = WB_MDR;
            state_next = S_FETCH;
         end

         S_BRANCH: begin
            alu_src_a  = ASRC_RS1;
            alu_src_b  = BSRC_RS2;
            alu_op     = ALU_SUB;
            pc_src     = 1'b1;
            pc_write   = (funct3 == F3_BEQ) ? zero :
                         (funct3 == F3_BNE) ? !zero : 1'b0;
            state_next = S_FETCH;
         end

         S_JAL: begin
            imm_sel    = IMM_J;
            alu_src_a  = ASRC_OLDPC;
            alu_src_b  = BSRC_IMM;
            pc_write   = 1'b1;
            reg_write  = 1'b1;
            wb_sel     = WB_PC4;
            state_next = S_FETCH;
         end

         S_JALR: begin
            imm_sel    = IMM_I;
            alu_src_a  = ASRC_RS1;
            alu_src_b  = BSRC_IMM;
            pc_write   = 1'b1;
            reg_write  = 1'b1;
            wb_sel     = WB_PC4;
            state_next = S_FETCH;
         end

         S_LUI: begin
            imm_sel    = IMM_U;
            reg_write  = 1'b1;
            wb_sel     = WB_IMM;
            state_next = S_FETCH;
         end

         S_TRAP:  state_next = S_TRAP;

         default: state_next = S_RESET;
      endcase
   end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo: per-cycle expected control vectors are
// queued when stimulus is applied and checked mid-cycle against the DUTs.
module tb_uc_multiciclo;
   import uc_pkg::*;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, irw, req, we, asel, rw;
      logic [1:0] a, b, op;
      logic [2:0] imm;
      logic [1:0] wb;
      logic       pcs, trp, berr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       zero, mem_ready;

   logic       pc_write, ir_write, mem_req, mem_we, mem_addr_sel, reg_write, pc_src, trap, bus_err;
   logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;
   logic [2:0] imm_sel;
   logic [3:0] state_dbg;

   logic       n_pc_write, n_ir_write, n_mem_req, n_mem_we, n_mem_addr_sel, n_reg_write, n_pc_src, n_trap, n_bus_err;
   logic [1:0] n_alu_src_a, n_alu_src_b, n_alu_op, n_wb_sel;
   logic [2:0] n_imm_sel;
   logic [3:0] n_state_dbg;

   exp_t obs, obs_n;
   exp_t exp_q[$];
   exp_t alt_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   uc_multiciclo #(.OPCODE_W(7), .MEM_TIMEOUT(4), .TRAP_ON_ILLEGAL(1'b1)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel), .wb_sel(wb_sel),
      .pc_src(pc_src), .trap(trap), .bus_err(bus_err), .state_dbg(state_dbg)
   );

   uc_multiciclo #(.OPCODE_W(7), .MEM_TIMEOUT(4), .TRAP_ON_ILLEGAL(1'b0)) dut_nop (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
      .pc_write(n_pc_write), .ir_write(n_ir_write), .mem_req(n_mem_req), .mem_we(n_mem_we),
      .mem_addr_sel(n_mem_addr_sel), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
      .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .imm_sel(n_imm_sel), .wb_sel(n_wb_sel),
      .pc_src(n_pc_src), .trap(n_trap), .bus_err(n_bus_err), .state_dbg(n_state_dbg)
   );

   assign obs   = {state_dbg, pc_write, ir_write, mem_req, mem_we, mem_addr_sel, reg_write,
                   alu_src_a, alu_src_b, alu_op, imm_sel, wb_sel, pc_src, trap, bus_err};
   assign obs_n = {n_state_dbg, n_pc_write, n_ir_write, n_mem_req, n_mem_we, n_mem_addr_sel, n_reg_write,
                   n_alu_src_a, n_alu_src_b, n_alu_op, n_imm_sel, n_wb_sel, n_pc_src, n_trap, n_bus_err};

   function automatic exp_t mk(input logic [3:0] st, input logic pcw, irw, req, we, asel, rw,
                               input logic [1:0] a, b, op, input logic [2:0] imm,
                               input logic [1:0] wb, input logic pcs, trp, berr);
      return {st, pcw, irw, req, we, asel, rw, a, b, op, imm, wb, pcs, trp, berr};
   endfunction

   function automatic exp_t idle(input logic [3:0] st, input logic trp, berr);
      return mk(st, 0,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0, trp, berr);
   endfunction

   function automatic exp_t f_go();
      return mk(4'd1, 1,1,1,0,0,0, 2'b00,2'b01,2'b00, 3'b000, 2'b00, 0,0,0);
   endfunction

   function automatic exp_t f_wait();
      return mk(4'd1, 0,0,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0,0,0);
   endfunction

   function automatic exp_t dec();
      return mk(4'd2, 0,0,0,0,0,0, 2'b10,2'b10,2'b00, 3'b010, 2'b00, 0,0,0);
   endfunction

   task automatic cyc(input logic [6:0] opc, input logic [2:0] f3, input logic z, rdy,
                      input exp_t e, input string tag, input bit chk_nop = 1'b0,
                      input exp_t e_nop = '0);
      exp_t x;
      opcode = opc; funct3 = f3; zero = z; mem_ready = rdy;
      exp_q.push_back(e);
      if (chk_nop) alt_q.push_back(e_nop);
      @(negedge clk);
      x = exp_q.pop_front();
      vectors++;
      assert (obs === x) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, x);
      end
      if (chk_nop) begin
         x = alt_q.pop_front();
         vectors++;
         assert (obs_n === x) else begin
            miscompares++;
            $error("FAIL %s_nop observed=%h expected=%h", tag, obs_n, x);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      cyc(7'h00, 3'b000, 0, 0, idle(4'd0, 0, 0), {tag, "_hold"});
      rst = 1'b0;
      cyc(7'h00, 3'b000, 0, 0, idle(4'd0, 0, 0), {tag, "_rel"});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      rst = 1'b1; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      do_reset("reset");

      // R-type: FETCH, DECODE, EXEC_R, WB_ALU
      cyc(OP_R, 0, 0, 1, f_go(), "r_fetch");
      cyc(OP_R, 0, 0, 1, dec(), "r_decode");
      cyc(OP_R, 0, 0, 1, mk(4'd3, 0,0,0,0,0,0, 2'b01,2'b00,2'b10, 3'b000, 2'b00, 0,0,0), "r_exec");
      cyc(OP_R, 0, 0, 1, mk(4'd8, 0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0,0,0), "r_wb");

      // I-type
      cyc(OP_I, 0, 0, 1, f_go(), "i_fetch");
      cyc(OP_I, 0, 0, 1, dec(), "i_decode");
      cyc(OP_I, 0, 0, 1, mk(4'd4, 0,0,0,0,0,0, 2'b01,2'b10,2'b11, 3'b000, 2'b00, 0,0,0), "i_exec");
      cyc(OP_I, 0, 0, 1, mk(4'd8, 0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0,0,0), "i_wb");

      // Load with three wait states in MEM_RD: 8 cycles total
      cyc(OP_LOAD, 0, 0, 1, f_go(), "ld_fetch");
      cyc(OP_LOAD, 0, 0, 1, dec(), "ld_decode");
      cyc(OP_LOAD, 0, 0, 1, mk(4'd5, 0,0,0,0,0,0, 2'b01,2'b10,2'b00, 3'b000, 2'b00, 0,0,0), "ld_addr");
      for (int i = 0; i < 3; i++)
         cyc(OP_LOAD, 0, 0, 0, mk(4'd6, 0,0,1,0,1,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0,0,0), "ld_wait");
      cyc(OP_LOAD, 0, 0, 1, mk(4'd6, 0,0,1,0,1,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0,0,0), "ld_done");
      cyc(OP_LOAD, 0, 0, 1, mk(4'd9, 0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000, 2'b01, 0,0,0), "ld_wb");

      // Store
      cyc(OP_STORE, 0, 0, 1, f_go(), "st_fetch");
      cyc(OP_STORE, 0, 0, 1, dec(), "st_decode");
      cyc(OP_STORE, 0, 0, 1, mk(4'd5, 0,0,0,0,0,0, 2'b01,2'b10,2'b00, 3'b001, 2'b00, 0,0,0), "st_addr");
      cyc(OP_STORE, 0, 0, 1, mk(4'd7, 0,0,1,1,1,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0,0,0), "st_mem");

      // Branches: beq taken, bne not taken, bne taken, unsupported funct3
      cyc(OP_BRANCH, 3'b000, 1, 1, f_go(), "beq_fetch");
      cyc(OP_BRANCH, 3'b000, 1, 1, dec(), "beq_decode");
      cyc(OP_BRANCH, 3'b000, 1, 1, mk(4'd10, 1,0,0,0,0,0, 2'b01,2'b00,2'b01, 3'b000, 2'b00, 1,0,0), "beq_taken");
      cyc(OP_BRANCH, 3'b001, 1, 1, f_go(), "bne_fetch");
      cyc(OP_BRANCH, 3'b001, 1, 1, dec(), "bne_decode");
      cyc(OP_BRANCH, 3'b001, 1, 1, mk(4'd10, 0,0,0,0,0,0, 2'b01,2'b00,2'b01, 3'b000, 2'b00, 1,0,0), "bne_not_taken");
      cyc(OP_BRANCH, 3'b001, 0, 1, f_go(), "bne2_fetch");
      cyc(OP_BRANCH, 3'b001, 0, 1, dec(), "bne2_decode");
      cyc(OP_BRANCH, 3'b001, 0, 1, mk(4'd10, 1,0,0,0,0,0, 2'b01,2'b00,2'b01, 3'b000, 2'b00, 1,0,0), "bne_taken");
      cyc(OP_BRANCH, 3'b100, 1, 1, f_go(), "blt_fetch");
      cyc(OP_BRANCH, 3'b100, 1, 1, dec(), "blt_decode");
      cyc(OP_BRANCH, 3'b100, 1, 1, mk(4'd10, 0,0,0,0,0,0, 2'b01,2'b00,2'b01, 3'b000, 2'b00, 1,0,0), "blt_ignored");

      // JAL, JALR, LUI
      cyc(OP_JAL, 0, 0, 1, f_go(), "jal_fetch");
      cyc(OP_JAL, 0, 0, 1, dec(), "jal_decode");
      cyc(OP_JAL, 0, 0, 1, mk(4'd11, 1,0,0,0,0,1, 2'b10,2'b10,2'b00, 3'b100, 2'b10, 0,0,0), "jal_exec");
      cyc(OP_JALR, 0, 0, 1, f_go(), "jalr_fetch");
      cyc(OP_JALR, 0, 0, 1, dec(), "jalr_decode");
      cyc(OP_JALR, 0, 0, 1, mk(4'd12, 1,0,0,0,0,1, 2'b01,2'b10,2'b00, 3'b000, 2'b10, 0,0,0), "jalr_exec");
      cyc(OP_LUI, 0, 0, 1, f_go(), "lui_fetch");
      cyc(OP_LUI, 0, 0, 1, dec(), "lui_decode");
      cyc(OP_LUI, 0, 0, 1, mk(4'd13, 0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b011, 2'b11, 0,0,0), "lui_exec");

      // Ready arriving exactly as the wait counter hits the limit completes the access
      for (int i = 0; i < 4; i++)
         cyc(OP_LUI, 0, 0, 0, f_wait(), "edge_wait");
      cyc(OP_LUI, 0, 0, 1, f_go(), "edge_complete");
      cyc(OP_LUI, 0, 0, 1, dec(), "edge_decode");
      cyc(OP_LUI, 0, 0, 1, mk(4'd13, 0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b011, 2'b11, 0,0,0), "edge_lui");

      // Ready stuck low in FETCH: bus error and sticky trap
      for (int i = 0; i < 5; i++)
         cyc(OP_R, 0, 0, 0, f_wait(), "to_wait");
      cyc(OP_R, 0, 0, 0, idle(4'd14, 1, 1), "to_trap");
      cyc(OP_R, 0, 0, 1, idle(4'd14, 1, 1), "to_trap_hold");
      do_reset("to_clear");

      // Illegal opcode: trap in one build, silent return to FETCH in the other
      cyc(7'h7F, 0, 0, 1, f_go(), "ill_fetch", 1'b1, f_go());
      cyc(7'h7F, 0, 0, 1, dec(), "ill_decode", 1'b1, dec());
      cyc(7'h7F, 0, 0, 0, idle(4'd14, 1, 0), "ill_trap", 1'b1, f_wait());
      cyc(7'h7F, 0, 0, 0, idle(4'd14, 1, 0), "ill_trap_hold", 1'b1, f_wait());

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
- Multicycle successor to the single-cycle RV32I control unit: a Moore FSM sequencing FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared ALU and a unified memory with a ready handshake.
- Adds JALR, beq/bne resolution on the ALU zero flag, memory wait states with timeout, and a sticky trap for illegal opcodes and bus errors.
- Sits between the instruction register (opcode/funct3 inputs) and the datapath muxes, register file, PC and memory port.

Parameters:
- OPCODE_W, 7, opcode field width.
- MEM_TIMEOUT, 16, wait cycles allowed per memory access before bus error; 0 disables the timeout.
- TRAP_ON_ILLEGAL, 1, 1: illegal opcode enters TRAP; 0: treated as NOP (back to FETCH after DECODE).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  OPCODE_W  instruction[6:0]; valid from DECODE onward
- funct3  in  3  instruction[14:12]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  instruction register load
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (valid with mem_req)
- mem_addr_sel  out  1  0: address = PC, 1: address = ALUOut
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00: PC, 01: rs1, 10: oldPC
- alu_src_b  out  2  00: rs2, 01: constant 4, 10: immediate
- alu_op  out  2  00: add, 01: sub (compare), 10: R-type funct, 11: I-type funct
- imm_sel  out  3  000: I, 001: S, 010: B, 011: U, 100: J
- wb_sel  out  2  00: ALUOut, 01: MDR, 10: PC+4, 11: immediate (LUI)
- pc_src  out  1  0: ALU result, 1: ALUOut
- trap  out  1  sticky; set on illegal opcode or bus error
- bus_err  out  1  sticky; set on memory timeout
- state_dbg  out  4  current state encoding

Behaviour:
- States: RESET, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, JALR, LUI, TRAP.
- rst asserted: state = RESET; trap = bus_err = 0; wait counter = 0; all enables and selects = 0. RESET -> FETCH unconditionally on the next edge.
- FETCH: mem_req = 1, mem_addr_sel = 0. While mem_ready = 0, hold. When mem_ready = 1, in the same cycle: ir_write = 1, pc_write = 1, alu_src_a = 00, alu_src_b = 01, pc_src = 0 (PC <= PC+4); go to DECODE.
- DECODE: alu_src_a = 10, alu_src_b = 10, imm_sel = 010, alu_op = 00 (precompute branch target into ALUOut). Dispatch on opcode:
  - 0x33 -> EXEC_R
  - 0x13 -> EXEC_I
  - 0x03 and 0x23 -> ADDR
  - 0x63 -> BRANCH
  - 0x6F -> JAL
  - 0x67 -> JALR
  - 0x37 -> LUI
  - anything else -> TRAP, or FETCH when TRAP_ON_ILLEGAL = 0
- EXEC_R (a = 01, b = 00, op = 10) -> WB_ALU.
- EXEC_I (a = 01, b = 10, imm_sel = 000, op = 11) -> WB_ALU.
- ADDR (a = 01, b = 10, op = 00; imm_sel = 000 for load, 001 for store) -> MEM_RD for load, MEM_WR for store.
- MEM_RD: mem_req = 1, mem_addr_sel = 1; hold until mem_ready, then -> WB_MEM.
- MEM_WR: mem_req = 1, mem_we = 1, mem_addr_sel = 1; hold until mem_ready, then -> FETCH.
- WB_ALU: reg_write = 1, wb_sel = 00 -> FETCH. WB_MEM: reg_write = 1, wb_sel = 01 -> FETCH.
- BRANCH: a = 01, b = 00, op = 01, pc_src = 1. pc_write = zero when funct3 = 000, !zero when funct3 = 001, 0 otherwise (this output is Mealy on zero). -> FETCH.
- JAL: imm_sel = 100, a = 10, b = 10, op = 00, pc_src = 0, pc_write = 1, reg_write = 1, wb_sel = 10 -> FETCH.
- JALR: imm_sel = 000, a = 01, b = 10, op = 00, pc_src = 0, pc_write = 1, reg_write = 1, wb_sel = 10 -> FETCH.
- LUI: imm_sel = 011, reg_write = 1, wb_sel = 11 -> FETCH.
- Instruction latency with mem_ready held high: R/I = 4 cycles, load = 5, store = 4, branch/JAL/JALR/LUI = 3.
- Wait counter (width $clog2(MEM_TIMEOUT+1)):
  - Counts cycles with mem_req = 1 and mem_ready = 0; cleared on mem_ready and on leaving a memory state.
  - Counter reaching MEM_TIMEOUT with mem_ready still 0: next state TRAP, bus_err = 1, trap = 1.
  - mem_ready = 1 in the same cycle the counter reaches the limit: the access completes; no error.
- TRAP: absorbing state. All enables = 0, mem_req = 0; trap/bus_err hold. Only rst exits.
- rst mid-access drops mem_req asynchronously; there is no partial write-enable glitch because outputs decode from the state register.
- All outputs not listed for a state are 0.

Decomposition:
- Shared package uc_pkg: state enum (4 bits), opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI), imm_sel, alu_op, wb_sel and source-select encodings.
- Optional sub-module uc_mem_timer: wait counter plus timeout compare, instantiated once.

Test Plan:
- Reset then R-type (opcode 0x33), mem_ready = 1 -> states RESET, FETCH, DECODE, EXEC_R, WB_ALU; reg_write high exactly in cycle 4 after FETCH; next state FETCH.
- Load (0x03) with mem_ready low 3 cycles in MEM_RD -> mem_req and mem_addr_sel = 1 held 4 cycles; WB_MEM asserts reg_write with wb_sel = 01; total 8 cycles.
- Branch (0x63): funct3 = 000 with zero = 1 -> pc_write = 1, pc_src = 1; funct3 = 001 with zero = 1 -> pc_write = 0; funct3 = 100 -> pc_write = 0.
- JAL (0x6F) and JALR (0x67) -> 3 cycles; imm_sel 100 / 000; reg_write = 1, wb_sel = 10, pc_write = 1 in the same cycle.
- MEM_TIMEOUT = 4, mem_ready stuck low in FETCH -> TRAP after 4 wait cycles, bus_err = trap = 1, mem_req = 0; stays in TRAP until rst clears both flags.
- Opcode 0x7F with TRAP_ON_ILLEGAL = 1 -> TRAP, trap = 1, bus_err = 0; with TRAP_ON_ILLEGAL = 0 -> returns to FETCH with no writes.
